pipeline_ctrl: RTL

- Central stall/flush controller for the 5-stage rv32imc core; the consumer of the ID-stage load-use hazard request.
- Merges four stall sources and one control-flow redirect into per-stage register write-enables, bubble inserts and the PC write/select.
  - Stall sources: load-use, instruction-fetch wait, data-memory wait, multi-cycle mul/div busy.
- Contains a small FSM that discards a stale in-flight fetch after a redirect, plus a stall-cycle performance counter.

---
 rtl/pipeline_ctrl_if.sv | 46 ++++
 rtl/pipeline_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_if.sv
// Bundle of stall requests, redirect and per-stage control lines exchanged
// between the pipeline stages (master side) and the stall/flush controller
// (slave side).
interface pipeline_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  // Requests from the stages
  logic             load_use_stall;
  logic             imem_stall;
  logic             dmem_stall;
  logic             muldiv_busy;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             stall_cnt_clr;
  // Controls back to the stages
  logic             pc_we;
  logic             pc_sel_redirect;
  logic [XLEN-1:0]  redirect_pc_out;
  logic             if_id_we;
  logic             if_id_flush;
  logic             id_ex_we;
  logic             id_ex_flush;
  logic             ex_mem_we;
  logic             ex_mem_flush;
  logic             mem_wb_we;
  logic             mem_wb_flush;
  logic             fetch_drain;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output load_use_stall, imem_stall, dmem_stall, muldiv_busy,
           redirect_valid, redirect_pc, stall_cnt_clr,
    input  pc_we, pc_sel_redirect, redirect_pc_out, if_id_we, if_id_flush,
           id_ex_we, id_ex_flush, ex_mem_we, ex_mem_flush, mem_wb_we,
           mem_wb_flush, fetch_drain, stall_cycles
  );

  modport slave (
    input  load_use_stall, imem_stall, dmem_stall, muldiv_busy,
           redirect_valid, redirect_pc, stall_cnt_clr,
    output pc_we, pc_sel_redirect, redirect_pc_out, if_id_we, if_id_flush,
           id_ex_we, id_ex_flush, ex_mem_we, ex_mem_flush, mem_wb_we,
           mem_wb_flush, fetch_drain, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage core. Turns the four stall
// sources and the EX redirect into per-stage write enables and bubbles, drops
// a stale fetch after a redirect, and counts cycles in which the PC is held.
//
// Redirect handshake: redirect_valid is held by EX until it is accepted. It is
// accepted in any cycle where EX advances (no dmem_stall, no muldiv_busy);
// in that cycle pc_we=1 and pc_sel_redirect=1 load the target. There is no
// separate ready line: a frozen EX simply keeps presenting the same redirect.
module pipeline_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic ex_frozen;
  logic redirect_take;
  logic pc_we, pc_sel_redirect;
  logic if_id_we, if_id_flush, id_ex_we, id_ex_flush;
  logic ex_mem_we, ex_mem_flush, mem_wb_we, mem_wb_flush;

  assign ex_frozen     = bus.dmem_stall | bus.muldiv_busy;
  assign redirect_take = bus.redirect_valid & ~ex_frozen;

  // Per-stage enables/bubbles by priority; a bubble is only inserted into a
  // register that is being written this cycle.
  always_comb begin
    pc_we           = 1'b1;
    pc_sel_redirect = 1'b0;
    if_id_we        = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_we        = 1'b1;
    id_ex_flush     = 1'b0;
    ex_mem_we       = 1'b1;
    ex_mem_flush    = 1'b0;
    mem_wb_we       = 1'b1;
    mem_wb_flush    = 1'b0;
    if (rst) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_we     = 1'b0;
      id_ex_flush  = 1'b1;
      ex_mem_we    = 1'b0;
      ex_mem_flush = 1'b1;
      mem_wb_we    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (bus.dmem_stall) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (bus.muldiv_busy) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_flush = 1'b1;
    end else if (bus.redirect_valid) begin
      pc_sel_redirect = 1'b1;
      if_id_flush     = 1'b1;
      id_ex_flush     = 1'b1;
    end else if (bus.load_use_stall) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (bus.imem_stall || state_q == DRAIN) begin
      // In DRAIN the PC already holds the redirect target, so it is held.
      pc_we       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  // Next state of the stale-fetch tracker and the stall-cycle counter.
  always_comb begin
    state_d        = state_q;
    stall_cycles_d = stall_cycles_q;
    if (redirect_take) begin
      // An old-path fetch still outstanding must be discarded; a redirect
      // seen while already draining keeps draining.
      if (bus.imem_stall) begin
        state_d = DRAIN;
      end
    end else if (state_q == DRAIN && !bus.imem_stall) begin
      // The stale word returns this cycle and is flushed out of IF/ID.
      state_d = RUN;
    end
    if (bus.stall_cnt_clr) begin
      stall_cycles_d = '0;
    end else if (!pc_we) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.pc_we           = pc_we;
  assign bus.pc_sel_redirect = pc_sel_redirect;
  assign bus.redirect_pc_out = bus.redirect_pc;
  assign bus.if_id_we        = if_id_we;
  assign bus.if_id_flush     = if_id_flush;
  assign bus.id_ex_we        = id_ex_we;
  assign bus.id_ex_flush     = id_ex_flush;
  assign bus.ex_mem_we       = ex_mem_we;
  assign bus.ex_mem_flush    = ex_mem_flush;
  assign bus.mem_wb_we       = mem_wb_we;
  assign bus.mem_wb_flush    = mem_wb_flush;
  assign bus.fetch_drain     = ~rst & (state_q == DRAIN);
  assign bus.stall_cycles    = stall_cycles_q;

endmodule
